// File: rtl/fifo_rd_unpacker.sv
// Purpose : pop 128-bit FIFO words and serialise each into DATA_W/OUT_W beats, LSB slice first.
// Latency : first beat on m_valid two cycles after the first fifo_rden pulse; one beat per cycle sustained.
// Backpres: m_ready low holds the current beat; the two-word buffer absorbs the fixed read latency.
//
// Ports:
//   clk, rstn    - clock and asynchronous reset (rstn = 1 resets)
//   fifo_empty   - registered FIFO empty flag
//   fifo_rden    - FIFO pop request, data returns on fifo_rddata one cycle later
//   fifo_rddata  - FIFO read data
//   m_valid/m_ready/m_data/m_last - narrow output stream, m_last on the final slice of a word
//   word_cnt     - number of fully emitted words, saturating at WCNT_MAX
module fifo_rd_unpacker #(
    parameter int          DATA_W   = 128,
    parameter int          OUT_W    = 32,
    parameter logic [15:0] WCNT_MAX = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              fifo_empty,
    output logic              fifo_rden,
    input  logic [DATA_W-1:0] fifo_rddata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [OUT_W-1:0]  m_data,
    output logic              m_last,
    output logic [15:0]       word_cnt
);

    // DATA_W must be an integer multiple of OUT_W.
    localparam int BEATS  = DATA_W / OUT_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [DATA_W-1:0] buf_q [2];
    logic [DATA_W-1:0] buf_d [2];
    logic              head_q, head_d;
    logic              tail_q, tail_d;
    logic [1:0]        occ_q, occ_d;
    logic              rd_pend_q, rd_pend_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [15:0]       word_cnt_q, word_cnt_d;

    logic                        xfer;
    logic                        beat_is_last;
    logic                        last_xfer;
    logic [BEATS-1:0][OUT_W-1:0] head_word;

    // A read is only issued when the word it returns is guaranteed a slot,
    // counting the one already in flight, so captured data never overflows.
    assign fifo_rden = !fifo_empty && ((occ_q + {1'b0, rd_pend_q}) < 2'd2);

    assign head_word    = buf_q[head_q];
    assign beat_is_last = (beat_q == BEAT_W'(BEATS - 1));

    assign m_valid   = (occ_q != 2'd0);
    assign m_data    = head_word[beat_q];
    assign m_last    = m_valid && beat_is_last;
    assign word_cnt  = word_cnt_q;

    assign xfer      = m_valid && m_ready;
    assign last_xfer = xfer && beat_is_last;

    always_comb begin
        buf_d      = buf_q;
        head_d     = head_q;
        tail_d     = tail_q;
        occ_d      = occ_q;
        beat_d     = beat_q;
        word_cnt_d = word_cnt_q;
        rd_pend_d  = fifo_rden;

        // rd_pend marks the cycle in which the FIFO's read data is valid.
        if (rd_pend_q) begin
            buf_d[tail_q] = fifo_rddata;
            tail_d        = ~tail_q;
        end

        if (xfer) begin
            if (beat_is_last) begin
                beat_d = '0;
                head_d = ~head_q;
                if (word_cnt_q != WCNT_MAX) begin
                    word_cnt_d = word_cnt_q + 16'd1;
                end
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end

        // Capture and word retirement on the same edge cancel out.
        case ({rd_pend_q, last_xfer})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            occ_q      <= 2'd0;
            rd_pend_q  <= 1'b0;
            beat_q     <= '0;
            word_cnt_q <= 16'd0;
        end else begin
            buf_q[0]   <= buf_d[0];
            buf_q[1]   <= buf_d[1];
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            rd_pend_q  <= rd_pend_d;
            beat_q     <= beat_d;
            word_cnt_q <= word_cnt_d;
        end
    end

endmodule
